// File: rtl/fu_mul_sequencer_pkg.sv
// Shared function_unit select codes and the multiply sequencer state encodings.
package fu_mul_sequencer_pkg;

  localparam logic [4:0] FS_TSA = 5'd0;
  localparam logic [4:0] FS_INC = 5'd1;
  localparam logic [4:0] FS_ADD = 5'd2;
  localparam logic [4:0] FS_SUB = 5'd5;
  localparam logic [4:0] FS_AND = 5'd8;
  localparam logic [4:0] FS_OR  = 5'd10;
  localparam logic [4:0] FS_XOR = 5'd12;
  localparam logic [4:0] FS_NOT = 5'd14;
  localparam logic [4:0] FS_LSL = 5'd16;
  localparam logic [4:0] FS_LSR = 5'd17;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_TEST = 3'd1;
  localparam logic [2:0] ST_ADD  = 3'd2;
  localparam logic [2:0] ST_SHL  = 3'd3;
  localparam logic [2:0] ST_SHR  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

endpackage

// File: rtl/fu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the shared function_unit for every
// arithmetic step; it owns no adder or shifter of its own.
module fu_mul_sequencer
  import fu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_ITER = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             ovf,
  output logic             fu_own,
  output logic [WIDTH-1:0] fu_a,
  output logic [WIDTH-1:0] fu_b,
  output logic [4:0]       fu_fs,
  output logic [4:0]       fu_sh,
  input  logic [WIDTH-1:0] fu_f,
  input  logic             fu_c,
  input  logic             fu_z
);

  localparam int             IW        = $clog2(MAX_ITER + 1);
  localparam logic [IW-1:0]  LAST_ITER = IW'(MAX_ITER - 1);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    iter_d    = iter_q;
    ovf_acc_d = ovf_acc_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    fu_a      = '0;
    fu_b      = '0;
    fu_fs     = FS_TSA;
    fu_sh     = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d   = op_a;
          mplier_d  = op_b;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
          iter_d    = '0;
          state_d   = ST_TEST;
        end
      end
      ST_TEST: begin
        fu_a    = mplier_q;
        fu_b    = WIDTH'(1);
        fu_fs   = FS_AND;
        state_d = fu_z ? ST_SHL : ST_ADD;
      end
      ST_ADD: begin
        fu_a      = acc_q;
        fu_b      = mcand_q;
        fu_fs     = FS_ADD;
        acc_d     = fu_f;
        ovf_acc_d = ovf_acc_q | fu_c;
        state_d   = ST_SHL;
      end
      ST_SHL: begin
        fu_a    = mcand_q;
        fu_b    = mcand_q;
        fu_fs   = FS_LSL;
        fu_sh   = 5'd1;
        mcand_d = fu_f;
        // A set bit falling off the multiplicand only matters if a later multiplier bit would still add it.
        if (mcand_q[WIDTH-1] && (|mplier_q[WIDTH-1:1])) ovf_acc_d = 1'b1;
        state_d = ST_SHR;
      end
      ST_SHR: begin
        fu_a     = mplier_q;
        fu_b     = mplier_q;
        fu_fs    = FS_LSR;
        fu_sh    = 5'd1;
        mplier_d = fu_f;
        iter_d   = iter_q + IW'(1);
        state_d  = (fu_z || iter_q == LAST_ITER) ? ST_DONE : ST_TEST;
      end
      ST_DONE: begin
        product_d = acc_q;
        ovf_d     = ovf_acc_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      iter_q    <= '0;
      ovf_acc_q <= 1'b0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      iter_q    <= iter_d;
      ovf_acc_q <= ovf_acc_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign fu_own  = busy;
  assign done    = (state_q == ST_DONE);
  // The result is already visible in the DONE cycle, before the holding register loads it.
  assign product = done ? acc_q : product_q;
  assign ovf     = done ? ovf_acc_q : ovf_q;

endmodule

// File: tb/tb_fu_mul_sequencer.sv
// Scoreboard bench for fu_mul_sequencer with a behavioural function_unit partner and
// an arithmetic reference model (64-bit product, bit-count latency).
module tb_fu_mul_sequencer;
  import fu_mul_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        busy, done, ovf, fu_own, fu_c, fu_z;
  logic [31:0] product, fu_a, fu_b, fu_f;
  logic [4:0]  fu_fs, fu_sh;

  fu_mul_sequencer #(.WIDTH(32), .MAX_ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .ovf(ovf), .fu_own(fu_own),
    .fu_a(fu_a), .fu_b(fu_b), .fu_fs(fu_fs), .fu_sh(fu_sh),
    .fu_f(fu_f), .fu_c(fu_c), .fu_z(fu_z)
  );

  always #5 clk = ~clk;

  // Behavioural function_unit partner.
  always_comb begin
    fu_c = 1'b0;
    fu_f = fu_a;
    case (fu_fs)
      FS_TSA: fu_f = fu_a;
      FS_INC: {fu_c, fu_f} = {1'b0, fu_a} + 33'd1;
      FS_ADD: {fu_c, fu_f} = {1'b0, fu_a} + {1'b0, fu_b};
      FS_SUB: {fu_c, fu_f} = {1'b0, fu_a} - {1'b0, fu_b};
      FS_AND: fu_f = fu_a & fu_b;
      FS_OR:  fu_f = fu_a | fu_b;
      FS_XOR: fu_f = fu_a ^ fu_b;
      FS_NOT: fu_f = ~fu_a;
      FS_LSL: fu_f = fu_b << fu_sh;
      FS_LSR: fu_f = fu_b >> fu_sh;
      default: fu_f = fu_a;
    endcase
    fu_z = (fu_f == 32'd0);
  end

  typedef struct {
    logic [31:0] prod;
    logic        ovf;
    int unsigned done_cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0, n_bad = 0, n_done = 0;
  logic [31:0] held_prod = '0;
  logic        held_ovf = 1'b0;
  logic        exp_busy, exp_done;
  exp_t        cur;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: full-width product; one iteration per multiplier bit up to its top set bit (min 1),
  // 4 cycles for a set bit and 3 for a clear one, plus the DONE cycle.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int unsigned acc_cyc);
    exp_t        e;
    logic [63:0] p;
    int          n, lat;
    p = 64'(a) * 64'(b);
    n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    lat = 1;
    for (int i = 0; i < n; i++) lat += b[i] ? 4 : 3;
    e.prod     = p[31:0];
    e.ovf      = (p[63:32] != 32'd0);
    e.done_cyc = acc_cyc + lat - 1;
    return e;
  endfunction

  // Monitor: expectations for busy/done come from the scoreboard, not the DUT.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() != 0 && cyc > sb[0].done_cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_missing: no done by cycle %0d, expected at %0d", cyc, sb[0].done_cyc);
        void'(sb.pop_front());
      end
      exp_busy = (sb.size() != 0);
      exp_done = exp_busy && (cyc == sb[0].done_cyc);
      check("busy", 64'(busy), 64'(exp_busy));
      check("fu_own", 64'(fu_own), 64'(exp_busy));
      check("done", 64'(done), 64'(exp_done));
      if (done) n_done++;
      if (!exp_busy) begin
        check("idle_fs", 64'(fu_fs), 64'(FS_TSA));
        check("idle_ab", {fu_a, fu_b}, 64'd0);
      end
      if (exp_done) begin
        cur = sb.pop_front();
        check("product", 64'(product), 64'(cur.prod));
        check("ovf", 64'(ovf), 64'(cur.ovf));
        held_prod = cur.prod;
        held_ovf  = cur.ovf;
      end else begin
        check("product_hold", 64'(product), 64'(held_prod));
        check("ovf_hold", 64'(ovf), 64'(held_ovf));
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    sb.push_back(model(a, b, cyc));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: operation still pending after %0d cycles", k);
      sb.delete();
    end
  endtask

  initial begin
    int d0;
    logic [31:0] ra, rb;

    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done_ovf", {62'd0, done, ovf}, 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_fu_ab", {fu_a, fu_b}, 64'd0);
    check("rst_fu_fs_sh", {54'd0, fu_fs, fu_sh}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Directed cases.
    issue(32'd6, 32'd7);                 wait_idle();
    issue(32'hAAAA_5555, 32'd2);         wait_idle();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    issue(32'h0001_0000, 32'h0001_0000); wait_idle();
    issue(32'd5, 32'd0);                 wait_idle();

    // Start re-pulsed mid-operation is ignored.
    d0 = n_done;
    issue(32'd6, 32'd7);
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b1; op_a = 32'd9; op_b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    @(negedge clk);
    check("single_done", 64'(n_done - d0), 64'd1);

    // Start raised during the DONE cycle is ignored.
    issue(32'd11, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; op_a = 32'd3; op_b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-operation.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    held_prod = '0;
    held_ovf  = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_fu_own", 64'(fu_own), 64'd0);
    check("midrst_fu_fs", 64'(fu_fs), 64'(FS_TSA));
    check("midrst_product", 64'(product), 64'd0);
    check("midrst_done_ovf", {62'd0, done, ovf}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(32'd6, 32'd7);
    wait_idle();

    // Randomized operands with varied multiplier lengths.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i % 5 == 0) ra = ra >> $urandom_range(0, 31);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(ra, rb);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
